instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 8-bit accumulator machine.
- Drives the instruction byte into the instruction decoder and owns the program counter.
- Arbitrates the single von Neumann memory between instruction fetch (PC address) and data access (accumulator address).
- Issues one commit pulse per instruction; the datapath gates all state writes (register file, accumulator, memory, PC) with it.

Parameters:
- PC_W, 8: program counter / memory address width.
- RESET_PC, 8'h00: PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = execute; 0 = stop at the next instruction boundary.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  PC_W  memory address.
- mem_ready  in  1  memory completion; rdata valid in the same cycle for reads.
- mem_rdata  in  8  memory read data.
- acc  in  8  accumulator value (data address and branch target).
- alu_nz  in  1  ALU "!= 0" result for BNZ.
- brnch  in  1  decoder branch flag.
- instr  out  8  latched instruction register (IR) to the decoder.
- ld_data  out  8  data captured for LW.
- commit  out  1  one-cycle pulse: end of instruction.
- pc  out  PC_W  current program counter.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state=IDLE, pc=RESET_PC, instr=0, ld_data=0.
  - mem_req=0, mem_we=0, commit=0, mem_addr=RESET_PC.
  - Reset mid-transaction drops mem_req at once; the memory tolerates an abandoned request.
- State machine:
  - IDLE: outputs quiet. If run=1 -> FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: IR<=mem_rdata -> DECODE. Otherwise stay, with mem_addr stable.
  - DECODE: one cycle for decoder outputs to settle, mem_req=0. If IR[7:6]==2'b11 -> MEM, else -> EXEC.
  - MEM: mem_req=1, mem_addr=acc, mem_we=(IR[7:5]==3'b110).
    - On mem_ready: if LW (3'b111), ld_data<=mem_rdata. Then -> EXEC.
    - mem_we is never asserted outside MEM.
  - EXEC: commit=1 for exactly this cycle, then PC update:
    - If brnch=1 and alu_nz=1: pc<=acc.
    - Otherwise pc<=pc+1, mod 2^PC_W (8'hFF wraps to 8'h00).
    - Next state: run=1 -> FETCH, run=0 -> IDLE.
- run is sampled only in IDLE and EXEC. Deasserting run mid-instruction completes the instruction.
- Cycle counts with zero-wait memory (mem_ready in the first request cycle):
  - non-memory instructions: 3 cycles (FETCH, DECODE, EXEC);
  - LW/SW: 4 cycles.
  - Each cycle mem_ready is low adds one cycle.
- mem_ready is ignored when mem_req=0.
- Branch target fetch: a branch to the address of the branch itself is legal (tight loop).
- instr holds its value from DECODE through the next FETCH completion, so the decoder sees a stable byte.
- ld_data holds its value until the next LW.
- busy = (state != IDLE).

Decomposition:
- Shared package (machine-wide):
  - opcode constants: ACM=3'b000, ACMI=3'b001, ADD=3'b010, NAND=3'b011, BNZ=3'b100, SLT=3'b101, SW=3'b110, LW=3'b111.
  - state enumeration IDLE/FETCH/DECODE/MEM/EXEC, 3-bit encoding.
  - RESET_PC default.
- Sub-module: pc_reg (PC register with increment/load/wrap).
- The state machine stays in the top module.

Test Plan:
- Reset then run=1, zero-wait memory, mem[0]=8'h41 (ADD) -> FETCH at addr 0, commit in cycle 3, pc=1, mem_we never high.
- SW at mem[5]=8'hC0 with acc=8'h20 -> MEM cycle drives mem_addr=8'h20, mem_we=1; commit on the 4th cycle; pc=6.
- LW at mem[6]=8'hE0, acc=8'h30, mem[8'h30]=8'hA5, mem_ready delayed 2 cycles -> ld_data=8'hA5, commit after 6 cycles, mem_req and mem_addr stable while waiting.
- BNZ with alu_nz=1, acc=8'h10 -> pc=8'h10. Repeat with alu_nz=0 -> pc=old+1. With pc=8'hFF and a non-branch -> pc=8'h00.
- run drops during MEM -> instruction completes, commit pulses once, state=IDLE, pc advanced, no further mem_req.
- rst_n low asynchronously during FETCH wait -> mem_req falls before the next clk edge, pc=RESET_PC. After release with run=1, fetch restarts at 0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Machine-wide definitions for the 8-bit accumulator machine: opcodes,
// sequencer states and the default reset program counter.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ACM  = 3'b000,
    OP_ACMI = 3'b001,
    OP_ADD  = 3'b010,
    OP_NAND = 3'b011,
    OP_BNZ  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SW   = 3'b110,
    OP_LW   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4
  } state_e;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  // LW and SW share the 2'b11 prefix; both need a data memory access.
  function automatic logic is_mem_op(input logic [7:0] ir);
    return ir[7:6] == 2'b11;
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_reg.sv
// Program counter: holds, increments (wrapping) or loads a branch target.
module instr_sequencer_pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Load wins over increment; the increment wraps naturally at 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/mem/exec sequencer: owns PC and IR, arbitrates the shared
// memory between instruction fetch and data access, pulses commit per instruction.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [7:0]      mem_rdata,
  input  logic [7:0]      acc,
  input  logic            alu_nz,
  input  logic            brnch,
  output logic [7:0]      instr,
  output logic [7:0]      ld_data,
  output logic            commit,
  output logic [PC_W-1:0] pc,
  output logic            busy
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] ld_q, ld_d;
  logic       pc_inc, pc_load;

  instr_sequencer_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (PC_W'(acc)),
    .pc_o       (pc)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ld_d     = ld_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    commit   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = is_mem_op(ir_q) ? ST_MEM : ST_EXEC;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = PC_W'(acc);
        mem_we   = (ir_q[7:5] == OP_SW);
        if (mem_ready) begin
          if (ir_q[7:5] == OP_LW) ld_d = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // run is only honoured here and in IDLE, so a stop never splits an instruction.
        commit  = 1'b1;
        pc_load = brnch && alu_nz;
        pc_inc  = !(brnch && alu_nz);
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= 8'h00;
      ld_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ld_q    <= ld_d;
    end
  end

  assign instr   = ir_q;
  assign ld_data = ld_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a memory responder with programmable wait states,
// a vector table of single-instruction steps, and hand-written stop/reset sequences.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata;
  logic [7:0] acc;
  logic       alu_nz;
  logic       brnch;
  logic [7:0] instr, ld_data;
  logic       commit;
  logic [7:0] pc;
  logic       busy;

  logic [7:0] mem [256];

  int n_vec  = 0;
  int n_miss = 0;

  // memory responder state
  int         fetch_wait, data_wait;
  int         cnt = 0;
  int         req_total = 0;
  int         req_base = 0;
  int         wr_cnt = 0;
  int         bad_we = 0;
  int         addr_unstable = 0;
  logic [7:0] req_addr0, fetch_addr, data_addr;
  logic       data_we;

  logic [7:0] model_pc, model_ld;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [7:0] ins;
    logic [7:0] a;
    logic [7:0] dat;
    logic       nz;
    int         fw;
    int         dw;
    logic [7:0] exp_pc;
    logic [7:0] exp_ld;
    int         exp_cyc;
  } vec_t;

  vec_t tbl[14];

  instr_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .acc       (acc),
    .alu_nz    (alu_nz),
    .brnch     (brnch),
    .instr     (instr),
    .ld_data   (ld_data),
    .commit    (commit),
    .pc        (pc),
    .busy      (busy)
  );

  // clock / decoder stand-in / memory read port
  always #5 clk = ~clk;
  assign brnch     = (instr[7:5] == 3'b100);
  assign mem_rdata = mem[mem_addr];

  // First request after req_base is the fetch, the next is the data access.
  always @(negedge clk) begin
    if (mem_we && (!mem_req || req_total == req_base)) bad_we++;
    if (!mem_req) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else begin
      if (cnt == 0) begin
        req_addr0 = mem_addr;
        if (req_total == req_base) fetch_addr = mem_addr;
        else begin
          data_addr = mem_addr;
          data_we   = mem_we;
        end
      end else if (mem_addr != req_addr0) begin
        addr_unstable++;
      end
      mem_ready = (cnt >= ((req_total == req_base) ? fetch_wait : data_wait));
      if (mem_ready) begin
        if (mem_we) wr_cnt++;
        req_total++;
      end
      cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Execute one instruction from IDLE with a single-cycle run pulse.
  task automatic run_one(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] dat,
                         input logic nz, input int fw, input int dw,
                         input logic [7:0] exp_pc, input logic [7:0] exp_ld, input int exp_cyc);
    logic [23:0] e;
    int          cyc;
    int          wr0;
    int          un0;
    bit          done;
    mem[a]        = dat;
    mem[model_pc] = ins;
    acc        = a;
    alu_nz     = nz;
    fetch_wait = fw;
    data_wait  = dw;
    req_base   = req_total;
    wr0 = wr_cnt;
    un0 = addr_unstable;
    exp_q.push_back({exp_pc, exp_ld, 8'(exp_cyc)});
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    cyc  = 0;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (commit) done = 1;
    end
    e = exp_q.pop_front();
    check("commit_seen", 32'(done), 32'd1);
    check("cycles", 32'(cyc), 32'(e[7:0]));
    @(posedge clk);
    #1;
    check("pc", 32'(pc), 32'(e[23:16]));
    check("ld_data", 32'(ld_data), 32'(e[15:8]));
    check("instr", 32'(instr), 32'(ins));
    check("busy_after", 32'(busy), 32'd0);
    check("fetch_addr", 32'(fetch_addr), 32'(model_pc));
    if (ins[7:6] == 2'b11) begin
      check("data_addr", 32'(data_addr), 32'(a));
      check("data_we", 32'(data_we), 32'(ins[7:5] == 3'b110));
    end
    check("writes", 32'(wr_cnt - wr0), (ins[7:5] == 3'b110) ? 32'd1 : 32'd0);
    check("addr_stable", 32'(addr_unstable - un0), 32'd0);
    model_pc = exp_pc;
    model_ld = exp_ld;
  endtask

  initial begin
    logic [7:0] ins, a, dat, epc, eld;
    logic [2:0] op;
    logic       nz;
    int         fw, dw, ecyc, n_commit, n_req_after;
    bit         found;
    logic [7:0] p0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    run = 1'b0;
    acc = 8'h00;
    alu_nz = 1'b0;
    fetch_wait = 0;
    data_wait = 0;
    model_pc = 8'h00;
    model_ld = 8'h00;

    //                ins    acc    dat    nz  fw dw  pc     ld     cyc
    tbl[0]  = '{8'h41, 8'h00, 8'h00, 1'b0, 0, 0, 8'h01, 8'h00, 3};
    tbl[1]  = '{8'h00, 8'h00, 8'h00, 1'b0, 0, 0, 8'h02, 8'h00, 3};
    tbl[2]  = '{8'h60, 8'h7F, 8'h00, 1'b1, 0, 0, 8'h03, 8'h00, 3};
    tbl[3]  = '{8'hA0, 8'h00, 8'h00, 1'b0, 0, 0, 8'h04, 8'h00, 3};
    tbl[4]  = '{8'h20, 8'h00, 8'h00, 1'b0, 1, 0, 8'h05, 8'h00, 4};
    tbl[5]  = '{8'hC0, 8'h20, 8'h00, 1'b0, 0, 0, 8'h06, 8'h00, 4};
    tbl[6]  = '{8'hE0, 8'h30, 8'hA5, 1'b0, 0, 2, 8'h07, 8'hA5, 6};
    tbl[7]  = '{8'h80, 8'h10, 8'h00, 1'b1, 0, 0, 8'h10, 8'hA5, 3};
    tbl[8]  = '{8'h9F, 8'h40, 8'h00, 1'b0, 0, 0, 8'h11, 8'hA5, 3};
    tbl[9]  = '{8'h80, 8'h11, 8'h00, 1'b1, 0, 0, 8'h11, 8'hA5, 3};
    tbl[10] = '{8'h80, 8'hFF, 8'h00, 1'b1, 0, 0, 8'hFF, 8'hA5, 3};
    tbl[11] = '{8'h41, 8'h00, 8'h00, 1'b0, 0, 0, 8'h00, 8'hA5, 3};
    tbl[12] = '{8'hE7, 8'h50, 8'h3C, 1'b0, 1, 1, 8'h01, 8'h3C, 6};
    tbl[13] = '{8'hD5, 8'h00, 8'h00, 1'b0, 0, 1, 8'h02, 8'h3C, 5};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_instr", 32'(instr), 32'h00);
    check("rst_ld_data", 32'(ld_data), 32'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_one(tbl[i].ins, tbl[i].a, tbl[i].dat, tbl[i].nz, tbl[i].fw, tbl[i].dw,
              tbl[i].exp_pc, tbl[i].exp_ld, tbl[i].exp_cyc);
    end

    // random instructions, expectations from a small reference model
    for (int i = 0; i < 10; i++) begin
      op  = 3'($urandom_range(0, 7));
      ins = {op, 5'($urandom_range(0, 31))};
      a   = 8'($urandom_range(0, 255));
      if (op[2:1] == 2'b11 && a == model_pc) a = a + 8'd1;
      dat = 8'($urandom_range(0, 255));
      nz  = 1'($urandom_range(0, 1));
      fw  = $urandom_range(0, 2);
      dw  = $urandom_range(0, 2);
      epc = (op == 3'b100 && nz) ? a : model_pc + 8'd1;
      eld = (op == 3'b111) ? dat : model_ld;
      ecyc = 3 + fw + ((op[2:1] == 2'b11) ? 1 + dw : 0);
      run_one(ins, a, dat, nz, fw, dw, epc, eld, ecyc);
    end

    // run deasserted while a store waits in MEM: the store completes, then stop
    p0 = model_pc;
    mem[p0] = 8'hC0;
    acc = (p0 == 8'h22) ? 8'h23 : 8'h22;
    alu_nz = 1'b0;
    fetch_wait = 0;
    data_wait = 3;
    req_base = req_total;
    @(negedge clk);
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1;
    end
    run = 1'b0;
    check("mem_state_seen", 32'(found), 32'd1);
    n_commit = 0;
    n_req_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (commit) n_commit++;
      else if (n_commit > 0 && mem_req) n_req_after++;
    end
    check("stop_commits", 32'(n_commit), 32'd1);
    check("stop_no_req", 32'(n_req_after), 32'd0);
    check("stop_pc", 32'(pc), 32'(p0 + 8'd1));
    check("stop_busy", 32'(busy), 32'd0);

    // asynchronous reset while a fetch is stalled
    fetch_wait = 1000;
    req_base = req_total;
    @(negedge clk);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'h00);
    check("arst_ld_data", 32'(ld_data), 32'h00);
    fetch_wait = 0;
    data_wait = 0;
    mem[0] = 8'h41;
    req_base = req_total;
    @(negedge clk);
    rst_n = 1'b1;
    fw = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      fw++;
      if (commit) begin
        found = 1;
        run = 1'b0;
      end
    end
    check("restart_commit", 32'(found), 32'd1);
    check("restart_cycles", 32'(fw), 32'd3);
    @(posedge clk);
    #1;
    check("restart_fetch_addr", 32'(fetch_addr), 32'h00);
    check("restart_pc", 32'(pc), 32'h01);

    check("mem_we_outside_data", 32'(bad_we), 32'd0);
    check("addr_stable_total", 32'(addr_unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
